// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter sharing one I2C master core between two clients
module i2c_req_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_rw,
  output logic [7:0]  m_wdata,
  input  logic        m_done,
  input  logic        m_nack,
  input  logic [7:0]  m_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2, REPORT = 2'd3;
  logic [1:0] state, mask, r;
  logic [CW-1:0] cnt;
  logic ptr, cur, any, win, expire;
  always_comb begin
    r = req & ~mask;
    any = |r;
    win = r[1] & (~r[0] | ptr);
    expire = cnt == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      done <= '0;
      rdata <= '0;
      err <= 1'b0;
      m_start <= 1'b0;
      m_addr <= '0;
      m_rw <= 1'b0;
      m_wdata <= '0;
      cnt <= '0;
      ptr <= 1'b0;
      cur <= 1'b0;
      // both clients blocked for the first idle edge so m_start trails reset release by two cycles
      mask <= 2'b11;
    end else begin
      m_start <= 1'b0;
      done <= '0;
      mask <= '0;
      case (state)
        IDLE: if (any) begin
          state <= ISSUE;
          cur <= win;
          ptr <= ~win;
          gnt <= {win, ~win};
          m_start <= 1'b1;
          m_addr <= win ? req_addr[13:7] : req_addr[6:0];
          m_rw <= req_rw[win];
          m_wdata <= win ? req_wdata[15:8] : req_wdata[7:0];
        end
        ISSUE: begin
          state <= WAIT_DONE;
          cnt <= '0;
        end
        WAIT_DONE: if (m_done || expire) begin
          state <= REPORT;
          gnt <= '0;
          done <= {cur, ~cur};
          rdata <= m_done ? m_rdata : 8'h00;
          err <= m_done ? m_nack : 1'b1;
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          rdata <= '0;
          err <= 1'b0;
          mask <= {cur, ~cur};
        end
      endcase
    end
  end
endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, the cycles to wait for m_done before aborting a transaction.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  2  per-client transaction request, level, bit i = client i.
REQ-005 SHALL have port req_addr  input  14  7-bit slave address per client, client i at [7i+6:7i].
REQ-006 SHALL have port req_rw  input  2  per-client direction, 1 = read, 0 = write.
REQ-007 SHALL have port req_wdata  input  16  write byte per client, client i at [8i+7:8i].
REQ-008 SHALL have port gnt  output  2  one-hot grant, high from ISSUE through WAIT_DONE.
REQ-009 SHALL have port done  output  2  one-cycle completion pulse to the served client.
REQ-010 SHALL have port rdata  output  8  read byte, valid while done is high.
REQ-011 SHALL have port err  output  1  high with done when the slave NACKed or the transaction timed out.
REQ-012 SHALL have port m_start  output  1  one-cycle start pulse to the shared I2C master core.
REQ-013 SHALL have ports m_addr (7), m_rw (1), m_wdata (8)  output  the command to the master core, registered, stable from ISSUE until REPORT.
REQ-014 SHALL have ports m_done (1), m_nack (1), m_rdata (8)  input  master core completion pulse, NACK flag and read byte, all sampled when m_done is high.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, WAIT_DONE and REPORT.
REQ-016 IDLE SHALL go to ISSUE on the first edge on which any unmasked req bit is high; otherwise it SHALL stay in IDLE.
REQ-017 Selection SHALL be round-robin: with both requesting, the client not most recently served wins. Client 0 SHALL win the first tie after reset.
REQ-018 On the IDLE->ISSUE edge, the arbiter SHALL latch gnt, m_addr, m_rw and m_wdata from the winning client. Latency is req high at edge N -> m_start high in cycle N+1.
REQ-019 ISSUE SHALL last exactly one cycle with m_start=1, then go to WAIT_DONE. It SHALL also clear the timeout counter.
REQ-020 WAIT_DONE SHALL count cycles. On m_done it SHALL capture m_rdata and m_nack, then go to REPORT.
REQ-021 If the counter reaches TIMEOUT without m_done, the arbiter SHALL go to REPORT with err=1 and rdata=0.
REQ-022 If m_done and the timeout expiry coincide, m_done SHALL take priority and err SHALL equal m_nack.
REQ-023 REPORT SHALL last one cycle:
- done[i]=1 for the served client, with rdata and err valid;
- gnt=0;
- next state IDLE.
REQ-024 In the IDLE cycle right after REPORT, the just-served client's req SHALL be masked, so a req held one cycle late is not re-granted.
REQ-025 A req deasserted before its grant SHALL be dropped silently. A req deasserted after its grant SHALL NOT abort the transaction; done still pulses.
REQ-026 m_done received outside WAIT_DONE SHALL be ignored.
REQ-027 m_start, done and gnt SHALL never be high for more than one client, or more than one pulse, per transaction.

Reset
REQ-028 While reset is high, the following SHALL all be 0 on the next edge:
- state=IDLE, gnt, done, rdata, err, m_start, m_addr, m_rw, m_wdata;
- timeout counter, round-robin pointer (client 0 priority).
REQ-029 A reset in any state, including mid-transaction, SHALL abandon the transaction without a done pulse. The first m_start after reset release SHALL come no earlier than two cycles after reset falls.

Verification
REQ-030 Client 0 write, addr 0x50, wdata 0xA5; m_done 20 cycles after m_start, m_nack=0 -> m_start 1 cycle after req, m_addr=0x50, m_rw=0, done=01, err=0.
REQ-031 Client 1 read, addr 0x3C; m_rdata=0x7E with m_done -> done=10, rdata=0x7E, err=0.
REQ-032 Both req high from reset, each re-requesting after done -> grants alternate 01,10,01,10; no gap beyond REQ-024 masking.
REQ-033 m_done never arrives, TIMEOUT=15 -> done pulse 16 cycles after ISSUE, err=1, rdata=0. Then m_done and expiry on the same cycle -> err=m_nack.
REQ-034 m_nack=1 with m_done -> err=1; req held one extra cycle after done -> no second m_start.
REQ-035 reset pulsed during WAIT_DONE -> all outputs 0, no done pulse, a later m_done ignored, next request served normally.
